// File: rtl/div_pkg.sv
// Shared definitions for the memory-mapped divider: register map,
// CTRL/STATUS bit positions and the core state encoding.
package div_pkg;

    localparam logic [3:0] ADDR_A      = 4'h0;
    localparam logic [3:0] ADDR_B      = 4'h2;
    localparam logic [3:0] ADDR_CTRL   = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h6;
    localparam logic [3:0] ADDR_Q      = 4'h8;
    localparam logic [3:0] ADDR_R      = 4'hA;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_DBZ  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_core.sv
// Sequential restoring divider core: one quotient bit per cycle on operand
// magnitudes, followed by a single sign-fixup cycle.
//
// state | meaning
// IDLE  | waiting for start; results and sticky flags held
// RUN   | WIDTH shift/subtract steps, down-counter reaches 0 on last step
// FIX   | apply signs, load Q/R, raise done
// ZERO  | divisor was zero; single busy cycle, results already loaded
module div_core
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             res_signed_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] bmag_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             mode_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             res_signed_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic             sub_ok;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // Operand magnitudes at start and one restoring step of the datapath.
    // The most-negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so overflow needs no special case.
    always_comb begin
        a_neg    = signed_i & a_i[WIDTH-1];
        b_neg    = signed_i & b_i[WIDTH-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        sub_ok   = (rem_sh >= {1'b0, bmag_q});
        rem_step = sub_ok ? WIDTH'(rem_sh - {1'b0, bmag_q}) : rem_sh[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], sub_ok};
    end

    // Control FSM with bit counter, working registers and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            bmag_q       <= '0;
            q_q          <= '0;
            r_q          <= '0;
            mode_q       <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            res_signed_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dbz_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q <= signed_i;
                        busy_q <= 1'b1;
                        if (b_i == '0) begin
                            state_q      <= ZERO;
                            q_q          <= '1;
                            r_q          <= a_i;
                            res_signed_q <= signed_i;
                            done_q       <= 1'b1;
                            dbz_q        <= 1'b1;
                        end else begin
                            state_q   <= RUN;
                            cnt_q     <= CW'(WIDTH - 1);
                            rem_q     <= '0;
                            quo_q     <= a_mag;
                            bmag_q    <= b_mag;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            done_q    <= 1'b0;
                            dbz_q     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    q_q          <= neg_quo_q ? -quo_q : quo_q;
                    r_q          <= neg_rem_q ? -rem_q : rem_q;
                    res_signed_q <= mode_q;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                ZERO: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q_o          = q_q;
    assign r_o          = r_q;
    assign res_signed_o = res_signed_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign dbz_o        = dbz_q;

endmodule

// File: rtl/peripheral_div_n.sv
// J1 I/O-bus divider peripheral: address decode, operand registers and the
// registered read mux around div_core. Results are right-aligned on the
// 16-bit bus, sign-extended when the completed operation was signed.
module peripheral_div_n
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [15:0]      d_out_d;
    logic [15:0]      d_out_q;

    logic             wr_en;
    logic             rd_en;
    logic             start;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;
    logic             res_signed;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [15:0]      q_ext;
    logic [15:0]      r_ext;

    // Only the low WIDTH bits of write data carry operands.
    logic             unused_d_in;
    assign unused_d_in = ^d_in;

    assign wr_en = cs & wr;
    assign rd_en = cs & rd;
    // The core drops a start that arrives while it is not idle.
    assign start = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_START];

    // Operand registers; rewriting them mid-operation does not disturb the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (wr_en) begin
            if (addr == ADDR_A) a_q <= d_in[WIDTH-1:0];
            if (addr == ADDR_B) b_q <= d_in[WIDTH-1:0];
        end
    end

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .signed_i     (d_in[CTRL_SIGNED]),
        .a_i          (a_q),
        .b_i          (b_q),
        .q_o          (core_q),
        .r_o          (core_r),
        .res_signed_o (res_signed),
        .busy_o       (busy),
        .done_o       (done),
        .dbz_o        (dbz)
    );

    if (WIDTH < 16) begin : g_ext
        assign q_ext = {{(16-WIDTH){res_signed & core_q[WIDTH-1]}}, core_q};
        assign r_ext = {{(16-WIDTH){res_signed & core_r[WIDTH-1]}}, core_r};
    end else begin : g_full
        assign q_ext = core_q;
        assign r_ext = core_r;
    end

    // Read mux; unmapped and write-only addresses read as zero.
    always_comb begin
        d_out_d = '0;
        if (rd_en) begin
            case (addr)
                ADDR_STATUS: begin
                    d_out_d[STAT_DONE] = done;
                    d_out_d[STAT_BUSY] = busy;
                    d_out_d[STAT_DBZ]  = dbz;
                end
                ADDR_Q:  d_out_d = q_ext;
                ADDR_R:  d_out_d = r_ext;
                default: d_out_d = '0;
            endcase
        end
    end

    // Registered read data, zero whenever no read was strobed.
    always_ff @(posedge clk) begin
        if (rst) d_out_q <= '0;
        else     d_out_q <= d_out_d;
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_div_n.sv
// Bench for peripheral_div_n: a 16-bit and an 8-bit instance share the bus
// and are selected by their own cs. Expected results are queued when an
// operation is started and compared when done is observed on STATUS.
module tb_peripheral_div_n;

    localparam logic [3:0] A_A      = 4'h0;
    localparam logic [3:0] A_B      = 4'h2;
    localparam logic [3:0] A_CTRL   = 4'h4;
    localparam logic [3:0] A_STATUS = 4'h6;
    localparam logic [3:0] A_Q      = 4'h8;
    localparam logic [3:0] A_R      = 4'hA;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs16, cs8, rd, wr;
    logic [3:0]  addr;
    logic [15:0] d_out16, d_out8;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    peripheral_div_n #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs16), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out16)
    );

    peripheral_div_n #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs8), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out8)
    );

    typedef struct {
        bit          w8;
        bit          sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic [2:0]  st;
    } vec_t;

    typedef struct {
        string       name;
        bit          w8;
        logic [15:0] q;
        logic [15:0] r;
        logic [2:0]  st;
        int          done_edge;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // All bus tasks start at a negedge and end one cycle later at a negedge.
    task automatic bus_write(input bit w8, input logic [3:0] ad, input logic [15:0] dt, output int edge_o);
        cs16 = !w8; cs8 = w8; wr = 1'b1; rd = 1'b0; addr = ad; d_in = dt;
        @(negedge clk);
        edge_o = cyc;
        cs16 = 1'b0; cs8 = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input bit w8, input logic [3:0] ad, output logic [15:0] dt);
        cs16 = !w8; cs8 = w8; rd = 1'b1; wr = 1'b0; addr = ad;
        @(negedge clk);
        dt = w8 ? d_out8 : d_out16;
        cs16 = 1'b0; cs8 = 1'b0; rd = 1'b0;
    endtask

    // Polls STATUS back to back; a read sampled at edge N shows the state
    // left by edge N-1, which identifies the edge that raised done.
    task automatic wait_done(input bit w8, output int done_edge, output bit ok);
        logic [15:0] st;
        ok = 1'b0;
        done_edge = -1;
        for (int i = 0; i < 60; i++) begin
            bus_read(w8, A_STATUS, st);
            if (st[0]) begin
                done_edge = cyc - 1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_op(input string name, input bit w8, input bit sgn,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] q, input logic [15:0] r, input logic [2:0] st);
        int   e;
        bit   zero;
        exp_t x;
        bus_write(w8, A_A, a, e);
        bus_write(w8, A_B, b, e);
        bus_write(w8, A_CTRL, {14'b0, sgn, 1'b1}, e);
        zero = w8 ? (b[7:0] == 8'h00) : (b == 16'h0000);
        x.name = name;
        x.w8 = w8;
        x.q = q;
        x.r = r;
        x.st = st;
        x.done_edge = zero ? e : e + (w8 ? 8 : 16) + 1;
        sb.push_back(x);
    endtask

    task automatic finish_op();
        exp_t        x;
        int          de;
        bit          ok;
        logic [15:0] v;
        x = sb.pop_front();
        wait_done(x.w8, de, ok);
        check({x.name, "_done_seen"}, 32'(ok), 32'd1);
        check({x.name, "_done_edge"}, de, x.done_edge);
        bus_read(x.w8, A_Q, v);
        check({x.name, "_q"}, v, x.q);
        bus_read(x.w8, A_R, v);
        check({x.name, "_r"}, v, x.r);
        bus_read(x.w8, A_STATUS, v);
        check({x.name, "_status"}, v, {13'b0, x.st});
    endtask

    function automatic void ref_div(input bit sgn, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r);
        int sa, sb_i;
        if (sgn) begin
            sa   = $signed(a);
            sb_i = $signed(b);
            q = 16'(sa / sb_i);
            r = 16'(sa % sb_i);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[13];
        logic [15:0] v;
        logic [15:0] ra, rb, rq, rr;
        bit          rs, seen;
        int          e;

        vecs[0]  = '{0, 0, 16'd100,  16'd7,    16'h000E, 16'h0002, 3'b001};
        vecs[1]  = '{0, 1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 3'b001};
        vecs[2]  = '{0, 1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 3'b001};
        vecs[3]  = '{0, 0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 3'b101};
        vecs[4]  = '{0, 0, 16'd20,   16'd6,    16'h0003, 16'h0002, 3'b001};
        vecs[5]  = '{1, 0, 16'h00FF, 16'h0010, 16'h000F, 16'h000F, 3'b001};
        vecs[6]  = '{1, 1, 16'h0080, 16'h00FF, 16'hFF80, 16'h0000, 3'b001};
        vecs[7]  = '{1, 1, 16'h00F9, 16'h0002, 16'hFFFD, 16'hFFFF, 3'b001};
        vecs[8]  = '{0, 1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 3'b001};
        vecs[9]  = '{0, 0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 3'b001};
        vecs[10] = '{1, 0, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 3'b101};
        vecs[11] = '{1, 1, 16'h0085, 16'h0000, 16'hFFFF, 16'hFF85, 3'b101};
        vecs[12] = '{0, 0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 3'b001};

        rst = 1'b1; cs16 = 1'b0; cs8 = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = 4'h0; d_in = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_dout", d_out16, 16'h0000);
        rst = 1'b0;
        bus_read(0, A_STATUS, v); check("reset_status16", v, 16'h0000);
        bus_read(0, A_Q, v);      check("reset_q16", v, 16'h0000);
        bus_read(0, A_R, v);      check("reset_r16", v, 16'h0000);
        bus_read(1, A_STATUS, v); check("reset_status8", v, 16'h0000);

        for (int i = 0; i < 13; i++) begin
            start_op($sformatf("vec%0d", i), vecs[i].w8, vecs[i].sgn, vecs[i].a, vecs[i].b,
                     vecs[i].q, vecs[i].r, vecs[i].st);
            finish_op();
        end

        // Busy status right after a start, and dbz cleared by that start.
        start_op("dbz_set", 0, 0, 16'h0042, 16'h0000, 16'hFFFF, 16'h0042, 3'b101);
        finish_op();
        start_op("dbz_clr", 0, 0, 16'h0042, 16'h0003, 16'h0016, 16'h0000, 3'b001);
        bus_read(0, A_STATUS, v);
        check("busy_after_start", v, 16'h0002);
        finish_op();

        // A start mid-run with new operands and signed mode is dropped.
        start_op("ign", 0, 0, 16'hFF00, 16'h0100, 16'h00FF, 16'h0000, 3'b001);
        bus_write(0, A_A, 16'h0007, e);
        bus_write(0, A_B, 16'h0002, e);
        bus_write(0, A_CTRL, 16'h0003, e);
        finish_op();
        repeat (3) @(negedge clk);
        bus_read(0, A_STATUS, v);
        check("ign_no_restart", v, 16'h0001);

        // Reset in the middle of a run.
        start_op("aborted", 0, 0, 16'd1000, 16'd3, 16'd333, 16'd1, 3'b001);
        void'(sb.pop_back());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_read(0, A_STATUS, v); check("rst_status", v, 16'h0000);
        bus_read(0, A_Q, v);      check("rst_q", v, 16'h0000);
        bus_read(0, A_R, v);      check("rst_r", v, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            bus_read(0, A_STATUS, v);
            if (v[0]) seen = 1'b1;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        start_op("after_rst", 0, 0, 16'd20, 16'd6, 16'h0003, 16'h0002, 3'b001);
        finish_op();

        // Read data returns to zero without a strobe; unmapped reads are zero.
        bus_read(0, A_Q, v);
        check("q_reread", v, 16'h0003);
        @(negedge clk);
        check("dout_idle_zero", d_out16, 16'h0000);
        bus_read(0, 4'hC, v); check("unmapped_c", v, 16'h0000);
        bus_read(0, A_A, v);  check("read_a_zero", v, 16'h0000);
        bus_read(0, 4'h9, v); check("unmapped_9", v, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 16'hFFFF));
            rs = 1'($urandom_range(0, 1));
            ref_div(rs, ra, rb, rq, rr);
            start_op($sformatf("rnd%0d", i), 0, rs, ra, rb, rq, rr, 3'b001);
            finish_op();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
